// File: rtl/giraffe_adc_if.sv
// ADC/host-side signal bundle for the giraffe_adc bridge.
// master = the bridge (drives the ADC control pins and the UART line).
interface giraffe_adc_if #(
    parameter int N_bit = 6
);
    logic             calib_ena_FPGA;
    logic             adc_ack;
    logic             adc_ack_sub;
    logic [N_bit-1:0] dout_adc;
    logic             tx2M;
    logic             rstn_adc;
    logic             clk_adc;
    logic             calib_ena_adc;

    modport master (
        input  calib_ena_FPGA, adc_ack, adc_ack_sub, dout_adc,
        output tx2M, rstn_adc, clk_adc, calib_ena_adc
    );

    modport slave (
        output calib_ena_FPGA, adc_ack, adc_ack_sub, dout_adc,
        input  tx2M, rstn_adc, clk_adc, calib_ena_adc
    );
endinterface

// File: rtl/giraffe_adc.sv
// SAR ADC test-chip bridge: divides clk_50M into clk_adc, drives ADC reset/calibration,
// captures each sub-conversion word and streams it to the host as one 8-N-1 UART byte.
module giraffe_adc #(
    parameter int BAUDRATE = 1_200_000,
    parameter int FREQ     = 50_000_000,
    parameter int N_start  = 1,
    parameter int N_data   = 8,
    parameter int N_stop   = 1,
    parameter int N_bit    = 6,
    parameter int NUM_DIV  = 5_000
) (
    input  logic          clk_50M,
    input  logic          nrst,
    giraffe_adc_if.master bus
);
    localparam int BIT_DIV   = FREQ / BAUDRATE;
    localparam int START_LEN = N_start * BIT_DIV;
    localparam int STOP_LEN  = N_stop * BIT_DIV;
    localparam int MAX_A     = (START_LEN > STOP_LEN) ? START_LEN : STOP_LEN;
    localparam int CNT_MAX   = (MAX_A > BIT_DIV) ? MAX_A : BIT_DIV;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int DW        = $clog2(NUM_DIV);
    localparam int IW        = (N_data > 1) ? $clog2(N_data) : 1;

    localparam logic [CW-1:0] START_LAST = CW'(START_LEN - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_DIV - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(N_data - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(NUM_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(NUM_DIV / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- front end: divider, synchronizers, holding register
    logic [1:0]             calib_sync_q, calib_sync_d;
    logic [1:0]             ack_sync_q, ack_sync_d;
    logic [1:0]             sub_sync_q, sub_sync_d;
    logic                   sub_prev_q, sub_prev_d;
    logic [1:0][N_bit-1:0]  dout_sync_q, dout_sync_d;
    logic [N_data-1:0]      buf_q, buf_d;
    logic                   full_q, full_d;
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic                   clk_adc_q, clk_adc_d;
    logic                   rstn_adc_q, rstn_adc_d;
    logic                   sub_rise;
    logic [N_data-1:0]      word;
    logic                   take;

    always_comb begin
        calib_sync_d = {calib_sync_q[0], bus.calib_ena_FPGA};
        ack_sync_d   = {ack_sync_q[0], bus.adc_ack};
        sub_sync_d   = {sub_sync_q[0], bus.adc_ack_sub};
        dout_sync_d  = {dout_sync_q[0], bus.dout_adc};
        sub_prev_d   = sub_sync_q[1];
        sub_rise     = sub_sync_q[1] & ~sub_prev_q;

        // {frame marker, calibration flag, zero pad, ADC word}
        word                 = '0;
        word[N_bit-1:0]      = dout_sync_q[1];
        word[N_data-1]       = ack_sync_q[1];
        word[N_data-2]       = calib_sync_q[1];

        // A fresh capture wins over a same-cycle hand-off to the transmitter
        buf_d  = buf_q;
        full_d = full_q;
        if (take) full_d = 1'b0;
        if (sub_rise) begin
            buf_d  = word;
            full_d = 1'b1;
        end

        div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        clk_adc_d  = (div_cnt_q < DIV_HALF);
        rstn_adc_d = 1'b1;
    end

    always_ff @(posedge clk_50M or posedge nrst) begin
        if (nrst) begin
            calib_sync_q <= '0;
            ack_sync_q   <= '0;
            sub_sync_q   <= '0;
            sub_prev_q   <= 1'b0;
            dout_sync_q  <= '0;
            buf_q        <= '0;
            full_q       <= 1'b0;
            div_cnt_q    <= '0;
            clk_adc_q    <= 1'b0;
            rstn_adc_q   <= 1'b0;
        end else begin
            calib_sync_q <= calib_sync_d;
            ack_sync_q   <= ack_sync_d;
            sub_sync_q   <= sub_sync_d;
            sub_prev_q   <= sub_prev_d;
            dout_sync_q  <= dout_sync_d;
            buf_q        <= buf_d;
            full_q       <= full_d;
            div_cnt_q    <= div_cnt_d;
            clk_adc_q    <= clk_adc_d;
            rstn_adc_q   <= rstn_adc_d;
        end
    end

    // ---------------- UART transmitter
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [N_data-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;

    // tx_d follows the next state so the line changes on the same edge as the state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (full_q) begin
                    take    = 1'b1;
                    shift_d = buf_q;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + IW'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_50M or posedge nrst) begin
        if (nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx2M          = tx_q;
    assign bus.clk_adc       = clk_adc_q;
    assign bus.rstn_adc      = rstn_adc_q;
    assign bus.calib_ena_adc = calib_sync_q[1];
endmodule

// File: tb/tb_giraffe_adc.sv
// Directed bench for giraffe_adc: vector table for single samples plus hand-written
// sequences for reset, divider timing, overwrite, free-running and ack-only cases.
module tb_giraffe_adc;
    localparam int BD = 41;
    localparam int FL = 10 * BD;

    logic clk_50M = 1'b0;
    logic nrst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    giraffe_adc_if #(.N_bit(6)) bus ();

    giraffe_adc dut (
        .clk_50M (clk_50M),
        .nrst    (nrst),
        .bus     (bus.master)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic [5:0] dout;
        logic       ack;
        logic       calib;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_start(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_50M);
            if (bus.tx2M === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Called on the first start-bit sample; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] exp, input string nm);
        logic [9:0] frame;
        logic [7:0] got;
        int         bad;
        frame = {1'b1, exp, 1'b0};
        got   = '0;
        bad   = 0;
        for (int i = 0; i < FL; i++) begin
            if (bus.tx2M !== frame[i / BD]) bad++;
            if ((i % BD) == BD / 2 && i >= BD && i < 9 * BD) got[i / BD - 1] = bus.tx2M;
            if (i != FL - 1) @(negedge clk_50M);
        end
        chk({nm, " byte"}, 32'(got), 32'(exp));
        chk({nm, " shape"}, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int hi, lo, lows;
        bit done;

        vecs[0] = '{6'h2A, 1'b0, 1'b0, 8'h2A};
        vecs[1] = '{6'h3F, 1'b1, 1'b1, 8'hFF};
        vecs[2] = '{6'h15, 1'b0, 1'b1, 8'h55};
        vecs[3] = '{6'h00, 1'b1, 1'b0, 8'h80};
        vecs[4] = '{6'h3F, 1'b0, 1'b0, 8'h3F};

        bus.calib_ena_FPGA = 1'b1;
        bus.adc_ack        = 1'b0;
        bus.adc_ack_sub    = 1'b0;
        bus.dout_adc       = '0;

        // Reset state and divider timing after release
        repeat (3) @(negedge clk_50M);
        chk("rst tx2M", bus.tx2M, 1);
        chk("rst clk_adc", bus.clk_adc, 0);
        chk("rst rstn_adc", bus.rstn_adc, 0);
        chk("rst calib_ena_adc", bus.calib_ena_adc, 0);
        nrst = 1'b0;
        @(negedge clk_50M);
        chk("rel rstn_adc", bus.rstn_adc, 1);
        chk("rel clk_adc rise", bus.clk_adc, 1);
        hi = 1; lo = 0; done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk_50M);
            if (bus.clk_adc) hi++;
            else begin lo = 1; done = 1'b1; end
        end
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk_50M);
            if (!bus.clk_adc) lo++;
            else done = 1'b1;
        end
        chk("clk_adc high cycles", hi, 2500);
        chk("clk_adc low cycles", lo, 2500);
        chk("calib sync", bus.calib_ena_adc, 1);

        // Single-sample vectors, latency and full frame shape
        for (int v = 0; v < 5; v++) begin
            bus.calib_ena_FPGA = vecs[v].calib;
            repeat (4) @(negedge clk_50M);
            bus.dout_adc    = vecs[v].dout;
            bus.adc_ack     = vecs[v].ack;
            bus.adc_ack_sub = 1'b1;
            repeat (3) @(negedge clk_50M);
            chk($sformatf("vec%0d pre-start", v), bus.tx2M, 1);
            @(negedge clk_50M);
            chk($sformatf("vec%0d start", v), bus.tx2M, 0);
            check_frame(vecs[v].exp, $sformatf("vec%0d", v));
            bus.adc_ack_sub = 1'b0;
            bus.adc_ack     = 1'b0;
            repeat (10) @(negedge clk_50M);
        end

        // Overwrite: two captures during a frame, only the newest survives
        bus.dout_adc    = 6'h10;
        bus.adc_ack_sub = 1'b1;
        wait_start(10, found);
        chk("ovw first start", found, 1);
        fork
            check_frame(8'h10, "ovw first");
            begin
                repeat (20) @(negedge clk_50M);
                bus.adc_ack_sub = 1'b0;
                repeat (30) @(negedge clk_50M);
                bus.dout_adc    = 6'h01;
                bus.adc_ack_sub = 1'b1;
                repeat (5) @(negedge clk_50M);
                bus.adc_ack_sub = 1'b0;
                repeat (95) @(negedge clk_50M);
                bus.dout_adc    = 6'h02;
                bus.adc_ack_sub = 1'b1;
                repeat (5) @(negedge clk_50M);
                bus.adc_ack_sub = 1'b0;
            end
        join
        wait_start(5, found);
        chk("ovw second start", found, 1);
        if (found) check_frame(8'h02, "ovw second");
        wait_start(600, found);
        chk("ovw no third frame", found, 0);

        // Free-running ADC: marker on every 4th sub-sample
        bus.calib_ena_FPGA = 1'b0;
        repeat (5) @(negedge clk_50M);
        fork
            for (int i = 0; i < 8; i++) begin
                bus.dout_adc    = 6'(5 + i);
                bus.adc_ack     = (i % 4 == 3);
                bus.adc_ack_sub = 1'b1;
                repeat (20) @(negedge clk_50M);
                bus.adc_ack_sub = 1'b0;
                bus.adc_ack     = 1'b0;
                repeat (580) @(negedge clk_50M);
            end
            for (int j = 0; j < 8; j++) begin
                bit f;
                logic [7:0] e;
                e = {(j % 4 == 3) ? 1'b1 : 1'b0, 1'b0, 6'(5 + j)};
                wait_start(700, f);
                chk($sformatf("run%0d start", j), f, 1);
                if (f) check_frame(e, $sformatf("run%0d", j));
            end
        join

        // adc_ack without adc_ack_sub must not emit anything
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_50M);
            if (i % 60 == 0) bus.adc_ack = 1'b1;
            if (i % 60 == 30) bus.adc_ack = 1'b0;
            if (bus.tx2M !== 1'b1) lows++;
        end
        bus.adc_ack = 1'b0;
        chk("ack alone tx low cycles", lows, 0);

        // Reset in the middle of a frame
        bus.calib_ena_FPGA = 1'b1;
        repeat (5) @(negedge clk_50M);
        bus.dout_adc    = 6'h2A;
        bus.adc_ack_sub = 1'b1;
        wait_start(10, found);
        chk("mid start", found, 1);
        repeat (15) @(negedge clk_50M);
        chk("mid in frame", bus.tx2M, 0);
        #3 nrst = 1'b1;
        #2;
        chk("mid rst tx2M", bus.tx2M, 1);
        chk("mid rst clk_adc", bus.clk_adc, 0);
        chk("mid rst rstn_adc", bus.rstn_adc, 0);
        chk("mid rst calib_ena_adc", bus.calib_ena_adc, 0);
        bus.adc_ack_sub = 1'b0;
        @(negedge clk_50M);
        nrst = 1'b0;
        @(negedge clk_50M);
        chk("mid rel rstn_adc", bus.rstn_adc, 1);
        wait_start(600, found);
        chk("mid frame abandoned", found, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
